mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle/memory/writeback signal group between the issue stage and the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              req0_valid;
  logic [1:0]        req0_op;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic [REG_W-1:0]  req0_rd;
  logic              req0_wen;
  logic              req1_valid;
  logic [1:0]        req1_op;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic [REG_W-1:0]  req1_rd;
  logic              req1_wen;
  logic              in_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb0_valid;
  logic [REG_W-1:0]  wb0_rd;
  logic [DATA_W-1:0] wb0_data;
  logic              wb0_wen;
  logic              wb1_valid;
  logic [REG_W-1:0]  wb1_rd;
  logic [DATA_W-1:0] wb1_data;
  logic              wb1_wen;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_addr, req0_data, req0_rd, req0_wen,
    input  req1_valid, req1_op, req1_addr, req1_data, req1_rd, req1_wen,
    input  mem_rdata,
    output in_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output wb0_valid, wb0_rd, wb0_data, wb0_wen,
    output wb1_valid, wb1_rd, wb1_data, wb1_wen, busy
  );

  modport master (
    output req0_valid, req0_op, req0_addr, req0_data, req0_rd, req0_wen,
    output req1_valid, req1_op, req1_addr, req1_data, req1_rd, req1_wen,
    output mem_rdata,
    input  in_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  wb0_valid, wb0_rd, wb0_data, wb0_wen,
    input  wb1_valid, wb1_rd, wb1_data, wb1_wen, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises a two-lane bundle onto one memory port, lane 0 first; writeback 2..4 cycles after accept.
// Backpressure: in_ready only in IDLE, so a new bundle waits until the previous one has written back.
module mem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave port_io
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DRAIN} state_e;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef struct packed {
    logic              vld;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
    logic [REG_W-1:0]  rd;
    logic              wen;
  } slot_t;

  typedef struct packed {
    logic              vld;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] dat;
    logic              wen;
  } wb_t;

  state_e            state_q, state_d;
  slot_t             slot0_q, slot0_d, slot1_q, slot1_d, acc;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              ld_pend_q, ld_pend_d, ld_lane_q, ld_lane_d;
  wb_t               wb0_q, wb0_d, wb1_q, wb1_d;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  function automatic slot_t capture(input logic vld, input logic [1:0] op,
                                    input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] dat,
                                    input logic [REG_W-1:0] rd, input logic wen);
    slot_t s;
    s.vld  = vld;
    s.op   = (op == 2'b11) ? OP_PASS : op;
    s.addr = addr;
    s.dat  = dat;
    s.rd   = rd;
    s.wen  = wen;
    return s;
  endfunction

  // Invalid lanes never touch memory, whatever their op field says.
  function automatic logic is_mem(input slot_t s);
    return s.vld && (s.op == OP_LOAD || s.op == OP_STORE);
  endfunction

  function automatic wb_t make_wb(input slot_t s, input logic [DATA_W-1:0] rdat);
    wb_t w;
    w.vld = s.vld;
    w.rd  = s.rd;
    w.wen = s.wen && (s.op != OP_STORE);
    case (s.op)
      OP_LOAD:  w.dat = rdat;
      OP_STORE: w.dat = '0;
      default:  w.dat = s.dat;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ld_pend_d = 1'b0;
    ld_lane_d = 1'b0;
    wb0_d     = '0;
    wb1_d     = '0;
    acc       = slot0_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Read data arrives the cycle after the load; a lane-1 load lands during DRAIN.
    if (ld_pend_q) begin
      if (ld_lane_q) rdata1_d = port_io.mem_rdata;
      else           rdata0_d = port_io.mem_rdata;
    end

    case (state_q)
      IDLE: begin
        if (port_io.req0_valid || port_io.req1_valid) begin
          slot0_d  = capture(port_io.req0_valid, port_io.req0_op, port_io.req0_addr,
                             port_io.req0_data, port_io.req0_rd, port_io.req0_wen);
          slot1_d  = capture(port_io.req1_valid, port_io.req1_op, port_io.req1_addr,
                             port_io.req1_data, port_io.req1_rd, port_io.req1_wen);
          rdata0_d = '0;
          rdata1_d = '0;
          if (is_mem(slot0_d))      state_d = ACC0;
          else if (is_mem(slot1_d)) state_d = ACC1;
          else                      state_d = DRAIN;
        end
      end
      ACC0, ACC1: begin
        acc       = (state_q == ACC1) ? slot1_q : slot0_q;
        mem_en    = 1'b1;
        mem_we    = (acc.op == OP_STORE);
        mem_addr  = acc.addr;
        mem_wdata = acc.dat;
        ld_pend_d = (acc.op == OP_LOAD);
        ld_lane_d = (state_q == ACC1);
        state_d   = (state_q == ACC0 && is_mem(slot1_q)) ? ACC1 : DRAIN;
      end
      DRAIN: begin
        wb0_d   = make_wb(slot0_q, rdata0_d);
        wb1_d   = make_wb(slot1_q, rdata1_d);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      slot0_q   <= '0;
      slot1_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      ld_pend_q <= 1'b0;
      ld_lane_q <= 1'b0;
      wb0_q     <= '0;
      wb1_q     <= '0;
    end else begin
      state_q   <= state_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      ld_pend_q <= ld_pend_d;
      ld_lane_q <= ld_lane_d;
      wb0_q     <= wb0_d;
      wb1_q     <= wb1_d;
    end
  end

  assign port_io.in_ready  = (state_q == IDLE);
  assign port_io.busy      = (state_q != IDLE);
  assign port_io.mem_en    = mem_en;
  assign port_io.mem_we    = mem_we;
  assign port_io.mem_addr  = mem_addr;
  assign port_io.mem_wdata = mem_wdata;
  assign port_io.wb0_valid = wb0_q.vld;
  assign port_io.wb0_rd    = wb0_q.rd;
  assign port_io.wb0_data  = wb0_q.dat;
  assign port_io.wb0_wen   = wb0_q.wen;
  assign port_io.wb1_valid = wb1_q.vld;
  assign port_io.wb1_rd    = wb1_q.rd;
  assign port_io.wb1_data  = wb1_q.dat;
  assign port_io.wb1_wen   = wb1_q.wen;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a sequential reference model.
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int RW = 3;

  typedef struct packed {
    logic          v;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
    logic          w;
  } lane_t;

  typedef struct {
    int            cyc;
    logic          v0, v1;
    logic [RW-1:0] rd0, rd1;
    logic [DW-1:0] d0, d1;
    logic          w0, w1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW)) dif();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW)) dut (
    .clk     (clk),
    .rst     (rst),
    .port_io (dif)
  );

  logic [DW-1:0] env_mem [32];
  logic [DW-1:0] ref_mem [32];
  exp_t          sbq[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM on the shared port.
  always @(posedge clk) begin
    if (dif.mem_en) begin
      if (dif.mem_we) env_mem[dif.mem_addr] <= dif.mem_wdata;
      else            dif.mem_rdata <= env_mem[dif.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dif.in_ready)
      chk("idle_mem_bus", 32'({dif.mem_en, dif.mem_we, dif.mem_addr, dif.mem_wdata}), 32'd0);
    if (dif.wb0_valid || dif.wb1_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_wb", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
        chk("wb_in_ready", 32'(dif.in_ready), 32'd1);
        chk("wb0_valid", 32'(dif.wb0_valid), 32'(e.v0));
        chk("wb1_valid", 32'(dif.wb1_valid), 32'(e.v1));
        if (e.v0) begin
          chk("wb0_rd", 32'(dif.wb0_rd), 32'(e.rd0));
          chk("wb0_data", 32'(dif.wb0_data), 32'(e.d0));
          chk("wb0_wen", 32'(dif.wb0_wen), 32'(e.w0));
        end
        if (e.v1) begin
          chk("wb1_rd", 32'(dif.wb1_rd), 32'(e.rd1));
          chk("wb1_data", 32'(dif.wb1_data), 32'(e.d1));
          chk("wb1_wen", 32'(dif.wb1_wen), 32'(e.w1));
        end
      end
    end
  end

  task automatic drive(input lane_t l0, input lane_t l1);
    dif.req0_valid = l0.v;  dif.req0_op = l0.op;  dif.req0_addr = l0.a;
    dif.req0_data  = l0.d;  dif.req0_rd = l0.rd;  dif.req0_wen  = l0.w;
    dif.req1_valid = l1.v;  dif.req1_op = l1.op;  dif.req1_addr = l1.a;
    dif.req1_data  = l1.d;  dif.req1_rd = l1.rd;  dif.req1_wen  = l1.w;
  endtask

  function automatic lane_t rnd_lane();
    lane_t l;
    l.v  = ($urandom_range(0, 3) != 0);
    l.op = 2'($urandom_range(0, 3));
    l.a  = AW'($urandom_range(0, 7));
    l.d  = DW'($urandom);
    l.rd = RW'($urandom);
    l.w  = 1'($urandom);
    return l;
  endfunction

  task automatic garbage();
    drive(rnd_lane(), rnd_lane());
  endtask

  // Program-order model: lane 0 completes fully before lane 1 sees memory.
  task automatic issue(input lane_t l0, input lane_t l1, input bit push);
    lane_t         l[2];
    logic [DW-1:0] dat[2];
    logic          wn[2];
    int            nops;
    exp_t          e;
    drive(l0, l1);
    if (!push || !(l0.v || l1.v)) return;
    l[0] = l0;
    l[1] = l1;
    nops = 0;
    for (int i = 0; i < 2; i++) begin
      dat[i] = l[i].d;
      wn[i]  = l[i].w;
      if (l[i].v) begin
        if (l[i].op == 2'b01) begin
          dat[i] = ref_mem[l[i].a];
          nops++;
        end else if (l[i].op == 2'b10) begin
          ref_mem[l[i].a] = l[i].d;
          dat[i] = '0;
          wn[i]  = 1'b0;
          nops++;
        end
      end
    end
    e.cyc = cyc + 2 + nops;
    e.v0 = l0.v;  e.rd0 = l0.rd;  e.d0 = dat[0];  e.w0 = wn[0];
    e.v1 = l1.v;  e.rd1 = l1.rd;  e.d1 = dat[1];  e.w1 = wn[1];
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!dif.in_ready && n < 20) begin
      garbage();
      @(negedge clk);
      n++;
    end
    if (!dif.in_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] v;
    int            n;
    for (int i = 0; i < 32; i++) begin
      v = DW'($urandom);
      env_mem[i] <= v;
      ref_mem[i] = v;
    end
    env_mem[31] <= 16'hBEEF;
    ref_mem[31] = 16'hBEEF;
    drive('0, '0);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_mem_en", 32'(dif.mem_en), 32'd0);
    chk("rst_wb_valid", 32'({dif.wb0_valid, dif.wb1_valid}), 32'd0);
    chk("rst_wb_fields", 32'({dif.wb0_data, dif.wb1_data}), 32'd0);
    rst = 1'b0;

    // store0 -> load1 forwarding through memory
    wait_idle();
    issue('{1'b1, 2'b10, 5'd5, 16'h1234, 3'd1, 1'b1}, '{1'b1, 2'b01, 5'd5, 16'h0000, 3'd2, 1'b1}, 1'b1);
    @(negedge clk);
    chk("acc0_store", 32'({dif.mem_en, dif.mem_we, dif.mem_addr, dif.mem_wdata}),
        32'({1'b1, 1'b1, 5'd5, 16'h1234}));
    garbage();
    @(negedge clk);
    chk("acc1_load", 32'({dif.mem_en, dif.mem_we, dif.mem_addr}), 32'({1'b1, 1'b0, 5'd5}));
    garbage();

    // pure pass-through bundle
    wait_idle();
    issue('{1'b1, 2'b00, 5'd3, 16'h00AA, 3'd1, 1'b1}, '{1'b1, 2'b11, 5'd4, 16'h0055, 3'd3, 1'b1}, 1'b1);
    @(negedge clk);
    chk("pass_no_mem", 32'(dif.mem_en), 32'd0);
    garbage();

    // lane 1 only, load of the top word; lane 0's store field must be ignored
    wait_idle();
    issue('{1'b0, 2'b10, 5'd9, 16'hDEAD, 3'd5, 1'b1}, '{1'b1, 2'b01, 5'd31, 16'h0000, 3'd4, 1'b1}, 1'b1);
    @(negedge clk);
    chk("lane1_only_acc", 32'({dif.mem_en, dif.mem_we, dif.mem_addr}), 32'({1'b1, 1'b0, 5'd31}));
    garbage();

    // two stores to the same word: lane 1 wins
    wait_idle();
    issue('{1'b1, 2'b10, 5'd7, 16'h1111, 3'd1, 1'b1}, '{1'b1, 2'b10, 5'd7, 16'h2222, 3'd2, 1'b1}, 1'b1);
    wait_idle();
    chk("mem7_final", 32'(env_mem[7]), 32'h2222);

    // asynchronous reset during ACC0: no writeback, lane 1 store never issued
    issue('{1'b1, 2'b10, 5'd9, 16'hAAAA, 3'd1, 1'b1}, '{1'b1, 2'b10, 5'd10, 16'h5555, 3'd2, 1'b1}, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive('0, '0);
    #1;
    chk("arst_mem_en", 32'({dif.mem_en, dif.mem_we, dif.mem_addr, dif.mem_wdata}), 32'd0);
    chk("arst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("arst_busy", 32'(dif.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_lane1_store", 32'(env_mem[10]), 32'(ref_mem[10]));
    chk("arst_lane0_store", 32'(env_mem[9]), 32'(ref_mem[9]));

    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (dif.in_ready) begin
        if ($urandom_range(0, 3) != 0) issue(rnd_lane(), rnd_lane(), 1'b1);
        else                           drive('0, '0);
      end else begin
        garbage();
      end
    end

    n = 0;
    @(negedge clk);
    while (!dif.in_ready && n < 20) begin
      garbage();
      @(negedge clk);
      n++;
    end
    drive('0, '0);
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), 32'(env_mem[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
